// File: rtl/debug_control.sv
// Debug controller: accepts run/step/reset command bytes, gates pipeline advance,
// and reports the fetch PC plus the enabled-cycle count as three transmitted bytes.
module debug_control #(
   parameter logic [7:0] CMD_RUN   = 8'h63,
   parameter logic [7:0] CMD_STEP  = 8'h73,
   parameter logic [7:0] CMD_RESET = 8'h72
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_data,
   input  logic       halt_detected,
   input  logic [7:0] programCounter_in,
   input  logic       tx_busy,
   output logic       enableDebug,
   output logic       resetDebug,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic [2:0] debug_state
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_RESET_PIPE = 3'd1,
      S_RUN        = 3'd2,
      S_STEP       = 3'd3,
      S_REPORT     = 3'd4,
      S_DONE       = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      PH_SEND = 2'd0,
      PH_GAP  = 2'd1,
      PH_WAIT = 2'd2
   } phase_t;

   state_t      state_r;
   phase_t      phase_r;
   logic [1:0]  byte_idx_r;
   logic [15:0] cycle_count_r;
   logic [15:0] count_next_s;
   logic [15:0] snap_count_r;
   logic [7:0]  snap_pc_r;
   logic        halted_r;
   logic [7:0]  report_byte_s;

   assign debug_state = state_r;

   // Next value of the saturating enabled-cycle counter; also feeds the snapshot
   always_comb begin
      count_next_s = cycle_count_r;
      if (enableDebug && (cycle_count_r != 16'hFFFF)) begin
         count_next_s = cycle_count_r + 16'd1;
      end else begin
         count_next_s = cycle_count_r;
      end
   end

   // Select the report byte for the current position in the three-byte sequence
   always_comb begin
      report_byte_s = 8'h00;
      case (byte_idx_r)
         2'd0:    report_byte_s = snap_pc_r;
         2'd1:    report_byte_s = snap_count_r[15:8];
         2'd2:    report_byte_s = snap_count_r[7:0];
         default: report_byte_s = 8'h00;
      endcase
   end

   // Main control FSM with registered outputs, counter, halted flag and snapshots
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= S_IDLE;
         phase_r       <= PH_SEND;
         byte_idx_r    <= 2'd0;
         cycle_count_r <= 16'd0;
         snap_count_r  <= 16'd0;
         snap_pc_r     <= 8'h00;
         halted_r      <= 1'b0;
         enableDebug   <= 1'b0;
         resetDebug    <= 1'b0;
         tx_start      <= 1'b0;
         tx_data       <= 8'h00;
      end else begin
         cycle_count_r <= count_next_s;
         tx_start      <= 1'b0;
         resetDebug    <= 1'b0;
         case (state_r)
            S_IDLE: begin
               enableDebug <= 1'b0;
               if (cmd_valid) begin
                  if (cmd_data == CMD_RUN) begin
                     state_r     <= S_RUN;
                     enableDebug <= 1'b1;
                  end else if (cmd_data == CMD_STEP) begin
                     state_r     <= S_STEP;
                     enableDebug <= 1'b1;
                  end else if (cmd_data == CMD_RESET) begin
                     state_r    <= S_RESET_PIPE;
                     resetDebug <= 1'b1;
                  end
               end
            end
            S_RESET_PIPE: begin
               enableDebug   <= 1'b0;
               cycle_count_r <= 16'd0;
               halted_r      <= 1'b0;
               state_r       <= S_IDLE;
            end
            S_RUN: begin
               if (halt_detected) begin
                  enableDebug  <= 1'b0;
                  halted_r     <= 1'b1;
                  state_r      <= S_REPORT;
                  snap_pc_r    <= programCounter_in;
                  snap_count_r <= count_next_s;
                  byte_idx_r   <= 2'd0;
                  phase_r      <= PH_SEND;
               end
            end
            S_STEP: begin
               enableDebug  <= 1'b0;
               if (halt_detected) begin
                  halted_r <= 1'b1;
               end
               state_r      <= S_REPORT;
               snap_pc_r    <= programCounter_in;
               snap_count_r <= count_next_s;
               byte_idx_r   <= 2'd0;
               phase_r      <= PH_SEND;
            end
            S_REPORT: begin
               enableDebug <= 1'b0;
               // Each byte: pulse when idle, skip one cycle, then wait for the transmitter
               case (phase_r)
                  PH_SEND: begin
                     if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= report_byte_s;
                        phase_r  <= PH_GAP;
                     end
                  end
                  PH_GAP: begin
                     phase_r <= PH_WAIT;
                  end
                  PH_WAIT: begin
                     if (!tx_busy) begin
                        phase_r <= PH_SEND;
                        if (byte_idx_r == 2'd2) begin
                           byte_idx_r <= 2'd0;
                           state_r    <= halted_r ? S_DONE : S_IDLE;
                        end else begin
                           byte_idx_r <= byte_idx_r + 2'd1;
                        end
                     end
                  end
                  default: begin
                     phase_r <= PH_SEND;
                  end
               endcase
            end
            S_DONE: begin
               enableDebug <= 1'b0;
               if (cmd_valid && (cmd_data == CMD_RESET)) begin
                  state_r    <= S_RESET_PIPE;
                  resetDebug <= 1'b1;
               end
            end
            default: begin
               enableDebug <= 1'b0;
               state_r     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_debug_control.sv
// Directed self-checking bench for debug_control: step, run/halt, done handling,
// transmitter back-pressure, counter saturation and reset during a report.
module tb_debug_control;

   logic       clk;
   logic       reset;
   logic       cmd_valid;
   logic [7:0] cmd_data;
   logic       halt_detected;
   logic [7:0] programCounter_in;
   logic       tx_busy;
   logic       enableDebug;
   logic       resetDebug;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [2:0] debug_state;

   int compared;
   int mismatched;

   debug_control dut (
      .clk               (clk),
      .reset             (reset),
      .cmd_valid         (cmd_valid),
      .cmd_data          (cmd_data),
      .halt_detected     (halt_detected),
      .programCounter_in (programCounter_in),
      .tx_busy           (tx_busy),
      .enableDebug       (enableDebug),
      .resetDebug        (resetDebug),
      .tx_start          (tx_start),
      .tx_data           (tx_data),
      .debug_state       (debug_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check("en_rst_exclusive", {31'd0, enableDebug & resetDebug}, 32'd0);
   endtask

   // Run a report to completion with a simple transmitter model
   task automatic collect(input int hold, input int busy_len,
                          output int n, output logic [23:0] got);
      int   busy_cnt;
      logic prev_busy;
      n = 0;
      got = 24'h0;
      busy_cnt = 0;
      for (int c = 0; c < 400; c++) begin
         if (debug_state != 3'd4) break;
         tx_busy = (c < hold) || (busy_cnt > 0);
         prev_busy = tx_busy;
         tick();
         if (busy_cnt > 0) busy_cnt--;
         if (tx_start) begin
            check("pulse_while_busy", {31'd0, prev_busy}, 32'd0);
            if (n < 3) got[8*(2-n) +: 8] = tx_data;
            n++;
            busy_cnt = busy_len;
         end
      end
      tx_busy = 1'b0;
      check("report_finished", {31'd0, debug_state == 3'd4}, 32'd0);
   endtask

   task automatic send_cmd(input logic [7:0] b);
      cmd_valid = 1'b1;
      cmd_data  = b;
      tick();
      cmd_valid = 1'b0;
      cmd_data  = 8'h00;
   endtask

   int          n;
   logic [23:0] got;
   int          pulses;

   initial begin
      compared = 0;
      mismatched = 0;
      reset = 1'b1;
      cmd_valid = 1'b1;
      cmd_data = 8'h73;
      halt_detected = 1'b1;
      programCounter_in = 8'h04;
      tx_busy = 1'b0;

      // Reset with simultaneous command and halt
      tick();
      tick();
      check("rst_state", {29'd0, debug_state}, 32'd0);
      check("rst_en", {31'd0, enableDebug}, 32'd0);
      check("rst_rstdbg", {31'd0, resetDebug}, 32'd0);
      check("rst_txs", {31'd0, tx_start}, 32'd0);
      check("rst_txd", {24'd0, tx_data}, 32'd0);
      reset = 1'b0;
      cmd_valid = 1'b0;
      halt_detected = 1'b0;
      tick();
      check("idle_after_rst", {29'd0, debug_state}, 32'd0);

      // Unknown byte ignored
      send_cmd(8'h55);
      check("unknown_cmd_state", {29'd0, debug_state}, 32'd0);
      check("unknown_cmd_en", {31'd0, enableDebug}, 32'd0);

      // Single step from reset
      send_cmd(8'h73);
      check("step_state", {29'd0, debug_state}, 32'd3);
      check("step_en", {31'd0, enableDebug}, 32'd1);
      tick();
      check("step_report", {29'd0, debug_state}, 32'd4);
      check("step_en_drop", {31'd0, enableDebug}, 32'd0);
      collect(0, 2, n, got);
      check("step_pulses", n, 32'd3);
      check("step_bytes", {8'd0, got}, 32'h00040001);
      check("step_idle", {29'd0, debug_state}, 32'd0);

      // Pipeline reset command clears the counter
      send_cmd(8'h72);
      check("rp_state", {29'd0, debug_state}, 32'd1);
      check("rp_pulse", {31'd0, resetDebug}, 32'd1);
      check("rp_en", {31'd0, enableDebug}, 32'd0);
      tick();
      check("rp_idle", {29'd0, debug_state}, 32'd0);
      check("rp_pulse_end", {31'd0, resetDebug}, 32'd0);

      // Run until halt after 10 enabled edges; command inside RUN ignored
      programCounter_in = 8'h3C;
      send_cmd(8'h63);
      check("run_state", {29'd0, debug_state}, 32'd2);
      check("run_en", {31'd0, enableDebug}, 32'd1);
      send_cmd(8'h72);
      check("run_ignore_state", {29'd0, debug_state}, 32'd2);
      check("run_ignore_rst", {31'd0, resetDebug}, 32'd0);
      repeat (8) tick();
      check("run_still_en", {31'd0, enableDebug}, 32'd1);
      halt_detected = 1'b1;
      tick();
      halt_detected = 1'b0;
      check("halt_en_drop", {31'd0, enableDebug}, 32'd0);
      check("halt_report", {29'd0, debug_state}, 32'd4);
      collect(0, 3, n, got);
      check("run_pulses", n, 32'd3);
      check("run_bytes", {8'd0, got}, 32'h003C000A);
      check("run_done", {29'd0, debug_state}, 32'd5);

      // DONE ignores everything but reset command
      send_cmd(8'h73);
      check("done_ign_step", {29'd0, debug_state}, 32'd5);
      check("done_en", {31'd0, enableDebug}, 32'd0);
      send_cmd(8'h63);
      check("done_ign_run", {29'd0, debug_state}, 32'd5);
      send_cmd(8'h72);
      check("done_rp_state", {29'd0, debug_state}, 32'd1);
      check("done_rp_pulse", {31'd0, resetDebug}, 32'd1);
      tick();
      check("done_rp_idle", {29'd0, debug_state}, 32'd0);
      check("done_rp_end", {31'd0, resetDebug}, 32'd0);

      // Step with transmitter busy for 20 cycles; count must restart at 1
      programCounter_in = 8'h10;
      send_cmd(8'h73);
      tick();
      collect(20, 1, n, got);
      check("busy_pulses", n, 32'd3);
      check("busy_bytes", {8'd0, got}, 32'h00100001);
      check("busy_idle", {29'd0, debug_state}, 32'd0);

      // Step with halt in the step cycle goes to DONE
      programCounter_in = 8'h22;
      send_cmd(8'h73);
      halt_detected = 1'b1;
      tick();
      halt_detected = 1'b0;
      collect(0, 0, n, got);
      check("stephalt_bytes", {8'd0, got}, 32'h00220002);
      check("stephalt_done", {29'd0, debug_state}, 32'd5);
      send_cmd(8'h72);
      tick();

      // Counter saturation, then reset during second report byte
      programCounter_in = 8'hA5;
      send_cmd(8'h63);
      repeat (65540) @(posedge clk);
      #1;
      halt_detected = 1'b1;
      tick();
      halt_detected = 1'b0;
      check("sat_report", {29'd0, debug_state}, 32'd4);
      for (int c = 0; c < 50; c++) begin
         tick();
         if (tx_start) break;
      end
      check("sat_b0_pulse", {31'd0, tx_start}, 32'd1);
      check("sat_b0_data", {24'd0, tx_data}, 32'h000000A5);
      tick();
      for (int c = 0; c < 50; c++) begin
         tick();
         if (tx_start) break;
      end
      check("sat_b1_pulse", {31'd0, tx_start}, 32'd1);
      check("sat_b1_data", {24'd0, tx_data}, 32'h000000FF);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_state", {29'd0, debug_state}, 32'd0);
      check("abort_txs", {31'd0, tx_start}, 32'd0);
      check("abort_txd", {24'd0, tx_data}, 32'd0);
      check("abort_en", {31'd0, enableDebug}, 32'd0);
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (tx_start) pulses++;
      end
      check("abort_no_pulse", pulses, 32'd0);

      // Reset cleared the counter
      programCounter_in = 8'h07;
      send_cmd(8'h73);
      tick();
      collect(0, 1, n, got);
      check("post_rst_bytes", {8'd0, got}, 32'h00070001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/debug_control.md
DEBUG_CONTROL -- requirements
Module: debug_control

Interface
REQ-001 Parameter CMD_RUN, default 8'h63, command byte that starts continuous execution.
REQ-002 Parameter CMD_STEP, default 8'h73, command byte that executes exactly one pipeline cycle.
REQ-003 Parameter CMD_RESET, default 8'h72, command byte that resets the pipeline.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  one-cycle strobe: cmd_data holds a received command byte.
REQ-007 cmd_data  input  8  command byte.
REQ-008 halt_detected  input  1  HALT instruction has reached writeback.
REQ-009 programCounter_in  input  8  current fetch PC, used for reporting.
REQ-010 tx_busy  input  1  transmitter is busy with a byte.
REQ-011 enableDebug  output  1  registered; pipeline latches advance only while this is 1.
REQ-012 resetDebug  output  1  registered; clears pipeline latches.
REQ-013 tx_start  output  1  registered one-cycle strobe: send tx_data.
REQ-014 tx_data  output  8  registered byte to transmit.
REQ-015 debug_state  output  3  current FSM state encoding.

Function
REQ-016 States and encodings: IDLE=0, RESET_PIPE=1, RUN=2, STEP=3, REPORT=4, DONE=5.
REQ-017 IDLE: enableDebug=0; cmd_valid with CMD_RUN->RUN, CMD_STEP->STEP, CMD_RESET->RESET_PIPE; other bytes are ignored.
REQ-018 Accepted command at edge N: enableDebug=1 from edge N+1 for RUN and STEP; resetDebug=1 from edge N+1 for RESET_PIPE.
REQ-019 RESET_PIPE: resetDebug high exactly one cycle; cycle_count and halted flag cleared; next state IDLE.
REQ-020 16-bit cycle_count increments on each edge where enableDebug is 1; it saturates at 16'hFFFF and does not wrap.
REQ-021 RUN: enableDebug held 1 until halt_detected is sampled 1; enableDebug=0 from the following edge; halted flag set; next state REPORT.
REQ-022 STEP: enableDebug=1 for exactly one cycle, then REPORT; halt_detected sampled 1 in that cycle sets the halted flag.
REQ-023 On REPORT entry, programCounter_in and cycle_count are captured into snapshot registers.
REQ-024 REPORT sends 3 bytes in order: PC, count[15:8], count[7:0].
REQ-025 Each byte is sent by a one-cycle tx_start pulse, and only when tx_busy=0.
REQ-026 After a tx_start pulse, the FSM waits at least one cycle, then waits for tx_busy=0 before the next byte.
REQ-027 After the third byte completes: halted flag 1 -> DONE; otherwise -> IDLE.
REQ-028 DONE: enableDebug=0; only CMD_RESET is accepted (->RESET_PIPE); all other commands are ignored.
REQ-029 cmd_valid in RUN, STEP, REPORT or RESET_PIPE is ignored and not queued.
REQ-030 enableDebug and resetDebug are never 1 in the same cycle.

Reset
REQ-031 reset=1 at an edge forces state IDLE; enableDebug, resetDebug, tx_start, tx_data, cycle_count, halted flag and snapshots all go to 0.
REQ-032 Reset has priority over any simultaneous cmd_valid or halt_detected.
REQ-033 Reset mid-REPORT aborts the report; no further tx_start pulse occurs.

Verification
REQ-034 Reset, then cmd 8'h73 with PC=8'h04 -> enableDebug high one cycle; tx bytes 8'h04, 8'h00, 8'h01; state returns to IDLE.
REQ-035 cmd 8'h63, halt_detected raised after 10 enabled cycles -> enableDebug drops next edge; count bytes 8'h00, 8'h0A (or 8'h0B per edge sampling, checked exactly against REQ-020); state DONE.
REQ-036 In DONE, cmd 8'h73 -> ignored; then cmd 8'h72 -> resetDebug single-cycle pulse; count cleared; state IDLE.
REQ-037 tx_busy held 1 for 20 cycles during REPORT -> no tx_start until tx_busy=0; exactly 3 pulses in total.
REQ-038 Force count to 16'hFFFF in RUN -> count stays 16'hFFFF; reset asserted during REPORT byte 2 -> outputs 0, state IDLE.
